// File: rtl/irq_ctrl.sv
// irq_ctrl: toggle-style interrupt controller with masking, priority arbitration, vectoring and in-service tracking
// Ports:
//   CLOCK, RESET_N       system clock, asynchronous active-low reset
//   i_irq[CHANNELS]      per-channel toggle request, any level change is one event
//   i_intf               CPU interrupt flag, gates o_req
//   i_ack / i_eoi        CPU accept pulse / RETI pulse
//   i_mask_we, i_mask    mask register write (1 = channel enabled)
//   i_ovr_clr            clear all overrun flags
//   o_req, o_vector      request and vector of the arbitrated channel
//   o_pending            raw pending latches (mask not applied)
//   o_inservice          in-service bits
//   o_overrun            sticky: event arrived while already pending
// Optional feature: define IRQ_NEST_EN to allow nesting of higher-priority channels.
module irq_ctrl #(
    parameter int          CHANNELS    = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'h0002,
    parameter int          VEC_STRIDE  = 2
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic [CHANNELS-1:0] i_irq,
    input  logic                i_intf,
    input  logic                i_ack,
    input  logic                i_eoi,
    input  logic                i_mask_we,
    input  logic [CHANNELS-1:0] i_mask,
    input  logic                i_ovr_clr,
    output logic                o_req,
    output logic [15:0]         o_vector,
    output logic [CHANNELS-1:0] o_pending,
    output logic [CHANNELS-1:0] o_inservice,
    output logic [CHANNELS-1:0] o_overrun
);
    localparam int          IW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0] LP_STRIDE = 16'(VEC_STRIDE);
`ifdef IRQ_NEST_EN
    localparam bit NEST_EN = 1'b1;
`else
    localparam bit NEST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t                               r_state, w_state_nx;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
    logic [SYNC_STAGES-1:0]               r_fill;
    logic                                 r_armed;
    logic [CHANNELS-1:0]                  r_prev, r_pend, r_insvc, r_ovr, r_mask;
    logic [15:0]                          r_vec;
    logic [IW-1:0]                        r_idx;
    logic [CHANNELS-1:0]                  w_sync, w_event, w_elig, w_cand, w_clr, w_is_low;
    logic [IW-1:0]                        w_idx;
    logic [15:0]                          w_vec;
    logic                                 w_any, w_load, w_take, w_eoi_take;

    assign w_sync = r_sync[SYNC_STAGES-1];
    // Events are suppressed until prev holds a real synchronised sample, so a level held through reset never fires.
    assign w_event  = {CHANNELS{r_armed}} & (w_sync ^ r_prev);
    assign w_cand   = r_pend & r_mask & w_elig;
    assign w_any    = |w_cand;
    assign w_vec    = VEC_BASE + 16'(w_idx) * LP_STRIDE;
    assign w_clr    = w_take ? (CHANNELS'(1) << r_idx) : '0;
    // Two's-complement trick isolates the lowest set in-service bit.
    assign w_is_low = r_insvc & (-r_insvc);

    always_comb begin
        w_elig = '0;
        for (int k = 0; k < CHANNELS; k++)
            // With nesting, channel k is eligible only if no in-service bit sits at index <= k.
            w_elig[k] = NEST_EN ? ~|(r_insvc << (CHANNELS - 1 - k)) : ~|r_insvc;
    end

    always_comb begin
        w_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (w_cand[k]) w_idx = IW'(k);
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_take     = 1'b0;
        w_eoi_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load     = w_any;
                w_state_nx = w_any ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                if (i_ack && i_intf) begin
                    w_take     = 1'b1;
                    w_state_nx = S_SERVICE;
                end else if (w_any) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nx = |r_insvc ? S_SERVICE : S_IDLE;
                end
            end
            S_SERVICE: begin
                if (i_eoi) begin
                    w_eoi_take = 1'b1;
                    w_state_nx = (NEST_EN && |(r_insvc & ~w_is_low)) ? S_SERVICE : S_IDLE;
                end else if (NEST_EN && w_any) begin
                    w_load     = 1'b1;
                    w_state_nx = S_REQ;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_armed <= 1'b0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_insvc <= '0;
            r_ovr   <= '0;
            r_mask  <= '1;
            r_vec   <= VEC_BASE;
            r_idx   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_armed <= r_fill[SYNC_STAGES-1];
            r_prev  <= w_sync;
            // A same-cycle event beats the ACK clear and is not an overrun.
            r_pend  <= (r_pend & ~w_clr) | w_event;
            r_ovr   <= (r_ovr & ~{CHANNELS{i_ovr_clr}}) | (w_event & r_pend & ~w_clr);
            r_insvc <= (r_insvc | w_clr) & ~({CHANNELS{w_eoi_take}} & w_is_low);
            if (i_mask_we) r_mask <= i_mask;
            if (w_load) begin
                r_vec <= w_vec;
                r_idx <= w_idx;
            end
        end
    end

    assign o_req       = (r_state == S_REQ) && i_intf;
    assign o_vector    = r_vec;
    assign o_pending   = r_pend;
    assign o_inservice = r_insvc;
    assign o_overrun   = r_ovr;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl against a behavioural reference model
module tb_irq_ctrl;
    localparam int N = 8;
    localparam int S = 2;
`ifdef IRQ_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic         CLOCK = 1'b0, RESET_N = 1'b0;
    logic [N-1:0] irq = '0, mask = '1;
    logic         intf = 1'b0, ack = 1'b0, eoi = 1'b0, mask_we = 1'b0, ovr_clr = 1'b0;
    logic         o_req;
    logic [15:0]  o_vector;
    logic [N-1:0] o_pending, o_inservice, o_overrun;

    irq_ctrl dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .i_irq(irq), .i_intf(intf), .i_ack(ack),
        .i_eoi(eoi), .i_mask_we(mask_we), .i_mask(mask), .i_ovr_clr(ovr_clr),
        .o_req(o_req), .o_vector(o_vector), .o_pending(o_pending),
        .o_inservice(o_inservice), .o_overrun(o_overrun)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic         req;
        logic [15:0]  vec;
        logic [N-1:0] pend, insvc, ovr;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0, miscompares = 0;

    // Reference model: phase 0 = idle, 1 = requesting, 2 = servicing.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_pend, m_insvc, m_ovr, m_mask;
    logic [15:0]  m_vec;
    int           m_phase, m_cur;

    // Staged inputs for the next cycle; pulse inputs self-clear after one cycle.
    logic [N-1:0] s_irq = '0, s_mask = '1;
    bit           s_intf, s_ack, s_eoi, s_we, s_clr, s_rst = 1'b1;

    function automatic logic [15:0] vec_of(input int k);
        return 16'(32'h0002 + k * 2);
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_pend = '0; m_insvc = '0; m_ovr = '0; m_mask = '1;
        m_vec = 16'h0002; m_phase = 0; m_cur = 0;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            bit elig = 1'b1;
            for (int j = 0; j < N; j++)
                if (m_insvc[j] && (!NEST || j <= k)) elig = 1'b0;
            if (m_pend[k] && m_mask[k] && elig) return k;
        end
        return -1;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] ev, new_ovr;
        int c, taken;
        ev = '0; new_ovr = '0; taken = -1;
        // A change becomes an event once it has aged through the synchroniser and been compared with its predecessor.
        if (hist.size() == S + 1) ev = hist[0] ^ hist[1];
        hist.push_back(irq);
        if (hist.size() > S + 1) void'(hist.pop_front());
        c = pick();
        if (m_phase == 0) begin
            if (c >= 0) begin m_cur = c; m_vec = vec_of(c); m_phase = 1; end
        end else if (m_phase == 1) begin
            if (ack && intf) begin taken = m_cur; m_phase = 2; end
            else if (c >= 0) begin m_cur = c; m_vec = vec_of(c); end
            else m_phase = (m_insvc != 0) ? 2 : 0;
        end else begin
            if (eoi) begin
                for (int k = 0; k < N; k++)
                    if (m_insvc[k]) begin m_insvc[k] = 1'b0; break; end
                m_phase = (NEST && m_insvc != 0) ? 2 : 0;
            end else if (NEST && c >= 0) begin
                m_cur = c; m_vec = vec_of(c); m_phase = 1;
            end
        end
        for (int k = 0; k < N; k++) begin
            bit was = m_pend[k];
            bit cl  = (taken == k);
            if (ev[k] && was && !cl) new_ovr[k] = 1'b1;
            m_pend[k] = ev[k] | (was & ~cl);
        end
        if (taken >= 0) m_insvc[taken] = 1'b1;
        m_ovr = (ovr_clr ? '0 : m_ovr) | new_ovr;
        if (mask_we) m_mask = mask;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge CLOCK);
        irq = s_irq; intf = s_intf; ack = s_ack; eoi = s_eoi;
        mask_we = s_we; mask = s_mask; ovr_clr = s_clr;
        s_ack = 1'b0; s_eoi = 1'b0; s_we = 1'b0; s_clr = 1'b0;
        if (s_rst) begin
            RESET_N = 1'b0;
            model_reset();
            #1;
            vectors++;
            if (o_req !== 1'b0 || o_vector !== 16'h0002 || o_pending !== '0 || o_inservice !== '0 || o_overrun !== '0) begin
                miscompares++;
                $display("FAIL async_reset t=%0t got req=%b vec=%h pend=%h insvc=%h ovr=%h, need 0/0002/00/00/00",
                         $time, o_req, o_vector, o_pending, o_inservice, o_overrun);
            end
        end else begin
            RESET_N = 1'b1;
            model_edge();
        end
        e.req = (m_phase == 1) && intf;
        e.vec = m_vec; e.pend = m_pend; e.insvc = m_insvc; e.ovr = m_ovr;
        sbq.push_back(e);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                vectors++;
                if (o_req !== e.req || o_vector !== e.vec || o_pending !== e.pend ||
                    o_inservice !== e.insvc || o_overrun !== e.ovr) begin
                    miscompares++;
                    $display("FAIL cycle_check t=%0t got req=%b vec=%h pend=%h insvc=%h ovr=%h, need req=%b vec=%h pend=%h insvc=%h ovr=%h",
                             $time, o_req, o_vector, o_pending, o_inservice, o_overrun,
                             e.req, e.vec, e.pend, e.insvc, e.ovr);
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        // IRQ[0] held high through reset must not fire; a later toggle must.
        s_irq = 8'h01; s_intf = 1'b1; s_rst = 1'b1;
        ticks(3);
        s_rst = 1'b0;
        ticks(20);
        s_irq = 8'h00; ticks(6);
        s_ack = 1'b1; ticks(2);
        s_eoi = 1'b1; ticks(3);
        // Two simultaneous toggles: channel 2 wins, channel 5 follows after EOI.
        s_irq = 8'h24; ticks(6);
        s_ack = 1'b1; ticks(2);
        s_eoi = 1'b1; ticks(5);
        s_ack = 1'b1; ticks(2);
        s_eoi = 1'b1; ticks(3);
        // Double toggle on channel 3 while the CPU has interrupts off: overrun.
        s_intf = 1'b0;
        s_irq = 8'h2C; ticks(4);
        s_irq = 8'h24; ticks(6);
        s_clr = 1'b1; ticks(2);
        // Masked channel stays pending without a request, then unmasking raises it.
        s_we = 1'b1; s_mask = 8'hFE; ticks(1);
        s_intf = 1'b1;
        s_irq = 8'h25; ticks(4);
        s_ack = 1'b1; ticks(2);
        s_ack = 1'b1; ticks(2);
        s_we = 1'b1; s_mask = 8'hFF; ticks(3);
        // ACK ignored while interrupts are off, then accepted; reset mid-service.
        s_intf = 1'b0; s_ack = 1'b1; ticks(2);
        s_intf = 1'b1; s_ack = 1'b1; ticks(2);
        s_rst = 1'b1; ticks(2);
        s_rst = 1'b0; ticks(4);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 9) == 0) s_irq[k] = ~s_irq[k];
            s_intf = ($urandom_range(0, 7) != 0);
            s_ack  = ($urandom_range(0, 2) == 0);
            s_eoi  = ($urandom_range(0, 3) == 0);
            s_clr  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) begin
                s_we   = 1'b1;
                s_mask = 8'($urandom) | 8'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                s_irq = 8'($urandom);
                s_rst = 1'b1;
                ticks($urandom_range(1, 3));
                s_rst = 1'b0;
            end
            tick();
        end
        repeat (3) @(posedge CLOCK);
        #2;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d entries left, need 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
